// File: rtl/amba_axi4_burst_monitor.sv
// rtl/amba_axi4_burst_monitor.sv - passive AXI4 burst-level protocol monitor
// Optional VALID/payload stability check compiled in with AMBA_AXI4_MON_STABILITY_EN.
module amba_axi4_burst_monitor #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAXWAIT         = 16,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 AWVALID,
  input  logic                 AWREADY,
  input  logic [7:0]           AWLEN,
  input  logic                 WVALID,
  input  logic                 WREADY,
  input  logic                 WLAST,
  input  logic                 BVALID,
  input  logic                 BREADY,
  input  logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [7:0]           ARLEN,
  input  logic                 RVALID,
  input  logic                 RREADY,
  input  logic                 RLAST,
  output logic [8:0]           err_pulse,
  output logic [8:0]           err_sticky,
  output logic [CNT_WIDTH-1:0] wr_outstanding,
  output logic [CNT_WIDTH-1:0] rd_outstanding
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int TW    = $clog2(MAXWAIT + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]        WAIT_MAX = TW'(MAXWAIT);
  localparam logic [TW-1:0]        WAIT_LIM = TW'(MAXWAIT - 1);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  logic [7:0]           aw_fifo [MAX_OUTSTANDING];
  logic [7:0]           ar_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     aw_wr, aw_rd, ar_wr, ar_rd;
  logic [CNT_WIDTH-1:0] aw_cnt, b_pending;
  logic [7:0]           w_beat, r_beat;

  // The AR FIFO occupancy always equals rd_outstanding; the AW FIFO does not,
  // because completed bursts leave the FIFO before their B arrives.
  logic aw_push, w_ok, w_at_head, w_final, b_ok;
  logic ar_push, r_ok, r_at_head, r_final;
  assign aw_push   = aw_hs && (wr_outstanding != MAX_C);
  assign w_ok      = w_hs && (aw_cnt != '0);
  assign w_at_head = (w_beat == aw_fifo[aw_rd]);
  assign w_final   = w_ok && w_at_head;
  assign b_ok      = b_hs && (b_pending != '0);
  assign ar_push   = ar_hs && (rd_outstanding != MAX_C);
  assign r_ok      = r_hs && (rd_outstanding != '0);
  assign r_at_head = (r_beat == ar_fifo[ar_rd]);
  assign r_final   = r_ok && r_at_head;

  logic [4:0]    stall;
  logic [TW-1:0] wait_cnt [5];
  logic          timeout_hit;
  assign stall = {RVALID & ~RREADY, ARVALID & ~ARREADY, BVALID & ~BREADY,
                  WVALID & ~WREADY, AWVALID & ~AWREADY};

  always_comb begin
    timeout_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (stall[i] && (wait_cnt[i] == WAIT_LIM)) timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    for (int i = 0; i < 5; i++) begin
      if (!ARESETn || !stall[i]) wait_cnt[i] <= '0;
      else if (wait_cnt[i] != WAIT_MAX) wait_cnt[i] <= wait_cnt[i] + TW'(1);
    end
  end

  logic stab_err;
`ifdef AMBA_AXI4_MON_STABILITY_EN
  logic [4:0] prev_stall;
  logic [7:0] prev_awlen, prev_arlen;
  logic       prev_wlast, prev_rlast;

  assign stab_err = (prev_stall[0] && (!AWVALID || (AWLEN != prev_awlen))) ||
                    (prev_stall[1] && (!WVALID  || (WLAST != prev_wlast)))  ||
                    (prev_stall[2] && !BVALID)                              ||
                    (prev_stall[3] && (!ARVALID || (ARLEN != prev_arlen))) ||
                    (prev_stall[4] && (!RVALID  || (RLAST != prev_rlast)));

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      prev_stall <= '0;
      prev_awlen <= '0;
      prev_arlen <= '0;
      prev_wlast <= 1'b0;
      prev_rlast <= 1'b0;
    end else begin
      prev_stall <= stall;
      prev_awlen <= AWLEN;
      prev_arlen <= ARLEN;
      prev_wlast <= WLAST;
      prev_rlast <= RLAST;
    end
  end
`else
  assign stab_err = 1'b0;
`endif

  logic [8:0] err_now;
  always_comb begin
    err_now    = '0;
    err_now[0] = aw_hs && (wr_outstanding == MAX_C);
    err_now[1] = ar_hs && (rd_outstanding == MAX_C);
    err_now[2] = w_hs && (aw_cnt == '0);
    err_now[3] = w_ok && (WLAST != w_at_head);
    err_now[4] = b_hs && (b_pending == '0);
    err_now[5] = r_hs && (rd_outstanding == '0);
    err_now[6] = r_ok && (RLAST != r_at_head);
    err_now[7] = timeout_hit;
    err_now[8] = stab_err;
  end

  always_ff @(posedge ACLK) begin
    if (aw_push) aw_fifo[aw_wr] <= AWLEN;
    if (ar_push) ar_fifo[ar_wr] <= ARLEN;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_wr          <= '0;
      aw_rd          <= '0;
      ar_wr          <= '0;
      ar_rd          <= '0;
      aw_cnt         <= '0;
      b_pending      <= '0;
      w_beat         <= '0;
      r_beat         <= '0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      err_pulse      <= '0;
      err_sticky     <= '0;
    end else begin
      if (aw_push) aw_wr <= aw_wr + PTR_W'(1);
      if (w_final) aw_rd <= aw_rd + PTR_W'(1);
      if (ar_push) ar_wr <= ar_wr + PTR_W'(1);
      if (r_final) ar_rd <= ar_rd + PTR_W'(1);
      if (w_ok) w_beat <= w_final ? 8'd0 : w_beat + 8'd1;
      if (r_ok) r_beat <= r_final ? 8'd0 : r_beat + 8'd1;
      aw_cnt         <= aw_cnt + CNT_WIDTH'(aw_push) - CNT_WIDTH'(w_final);
      b_pending      <= b_pending + CNT_WIDTH'(w_final) - CNT_WIDTH'(b_ok);
      wr_outstanding <= wr_outstanding + CNT_WIDTH'(aw_push) - CNT_WIDTH'(b_ok);
      rd_outstanding <= rd_outstanding + CNT_WIDTH'(ar_push) - CNT_WIDTH'(r_final);
      err_pulse      <= err_now;
      err_sticky     <= err_sticky | err_now;
    end
  end

endmodule

// File: tb/tb_amba_axi4_burst_monitor.sv
// tb/tb_amba_axi4_burst_monitor.sv - directed and random checks against a queue-based model
module tb_amba_axi4_burst_monitor;

  localparam int MAX     = 4;
  localparam int MAXWAIT = 16;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic       ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [7:0] AWLEN, ARLEN;
  logic [8:0] err_pulse, err_sticky;
  logic [2:0] wr_outstanding, rd_outstanding;

  amba_axi4_burst_monitor #(.MAX_OUTSTANDING(MAX), .MAXWAIT(MAXWAIT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  int aw_q[$];
  int ar_q[$];
  int w_beat, r_beat, b_pend, wr_out, rd_out;
  int wait_cnt [5];
  logic [8:0] m_pulse  = '0;
  logic [8:0] m_sticky = '0;
  logic [4:0] prev_stall = '0;
  logic [7:0] prev_awlen, prev_arlen;
  logic       prev_wlast, prev_rlast;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the protocol rules to the inputs about to be sampled at the next edge.
  task automatic model_edge();
    logic [8:0] e;
    logic [4:0] st;
    bit aw_ok, ar_ok, w_fin;
    int head;
    e = '0; aw_ok = 0; ar_ok = 0; w_fin = 0;
    st = {RVALID & ~RREADY, ARVALID & ~ARREADY, BVALID & ~BREADY,
          WVALID & ~WREADY, AWVALID & ~AWREADY};
    if (!ARESETn) begin
      aw_q.delete(); ar_q.delete();
      w_beat = 0; r_beat = 0; b_pend = 0; wr_out = 0; rd_out = 0;
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
      prev_stall = '0;
      m_pulse = '0; m_sticky = '0;
      return;
    end
    if (AWVALID && AWREADY) begin
      if (wr_out == MAX) e[0] = 1'b1; else aw_ok = 1;
    end
    if (ARVALID && ARREADY) begin
      if (rd_out == MAX) e[1] = 1'b1; else ar_ok = 1;
    end
    if (WVALID && WREADY) begin
      if (aw_q.size() == 0) e[2] = 1'b1;
      else begin
        head = aw_q[0];
        if (WLAST != (w_beat == head)) e[3] = 1'b1;
        if (w_beat == head) begin
          void'(aw_q.pop_front()); w_beat = 0; w_fin = 1;
        end else w_beat++;
      end
    end
    if (BVALID && BREADY) begin
      if (b_pend == 0) e[4] = 1'b1;
      else begin b_pend--; wr_out--; end
    end
    if (w_fin) b_pend++;
    if (aw_ok) begin aw_q.push_back(int'(AWLEN)); wr_out++; end
    if (RVALID && RREADY) begin
      if (ar_q.size() == 0) e[5] = 1'b1;
      else begin
        head = ar_q[0];
        if (RLAST != (r_beat == head)) e[6] = 1'b1;
        if (r_beat == head) begin
          void'(ar_q.pop_front()); r_beat = 0; rd_out--;
        end else r_beat++;
      end
    end
    if (ar_ok) begin ar_q.push_back(int'(ARLEN)); rd_out++; end
    for (int i = 0; i < 5; i++) begin
      if (st[i]) begin
        wait_cnt[i]++;
        if (wait_cnt[i] == MAXWAIT) e[7] = 1'b1;
      end else wait_cnt[i] = 0;
    end
`ifdef AMBA_AXI4_MON_STABILITY_EN
    if (prev_stall[0] && (!AWVALID || AWLEN != prev_awlen)) e[8] = 1'b1;
    if (prev_stall[1] && (!WVALID || WLAST != prev_wlast)) e[8] = 1'b1;
    if (prev_stall[2] && !BVALID) e[8] = 1'b1;
    if (prev_stall[3] && (!ARVALID || ARLEN != prev_arlen)) e[8] = 1'b1;
    if (prev_stall[4] && (!RVALID || RLAST != prev_rlast)) e[8] = 1'b1;
`endif
    prev_stall = st;
    prev_awlen = AWLEN; prev_arlen = ARLEN;
    prev_wlast = WLAST; prev_rlast = RLAST;
    m_pulse  = e;
    m_sticky = m_sticky | e;
  endtask

  task automatic tick();
    model_edge();
    @(posedge ACLK);
    #1;
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("wr_outstanding", 32'(wr_outstanding), wr_out);
    check("rd_outstanding", 32'(rd_outstanding), rd_out);
  endtask

  task automatic idle();
    ARESETn = 1'b1;
    AWVALID = 0; AWREADY = 0; AWLEN = 0; WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 0; BREADY = 0; ARVALID = 0; ARREADY = 0; ARLEN = 0;
    RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  task automatic do_reset();
    idle();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
  endtask

  int rdy;

  initial begin
    idle();
    do_reset();
    do_reset();
    check("reset_outputs", {err_pulse, err_sticky, 3'(wr_outstanding), 3'(rd_outstanding)}, 0);

    // Clean AWLEN=3 burst then B.
    AWVALID = 1; AWREADY = 1; AWLEN = 8'd3; tick(); idle();
    check("wr_out_after_aw", 32'(wr_outstanding), 1);
    for (int i = 0; i < 4; i++) begin
      WVALID = 1; WREADY = 1; WLAST = (i == 3); tick();
    end
    idle();
    BVALID = 1; BREADY = 1; tick(); idle();
    check("wr_out_after_b", 32'(wr_outstanding), 0);
    check("clean_write_sticky", 32'(err_sticky), 0);

    // ARLEN=1 with early RLAST.
    ARVALID = 1; ARREADY = 1; ARLEN = 8'd1; tick(); idle();
    RVALID = 1; RREADY = 1; RLAST = 1; tick();
    check("rlast_early_pulse", 32'(err_pulse), 32'h040);
    check("rd_out_mid", 32'(rd_outstanding), 1);
    tick(); idle();
    check("rd_out_done", 32'(rd_outstanding), 0);

    // Outstanding write overflow.
    do_reset();
    AWVALID = 1; AWREADY = 1; AWLEN = 0;
    for (int i = 0; i < 5; i++) tick();
    idle();
    check("aw_overflow_pulse", 32'(err_pulse), 32'h001);
    check("aw_overflow_count", 32'(wr_outstanding), 4);

    // Unexpected B, then W leading AW.
    do_reset();
    BVALID = 1; BREADY = 1; tick(); idle();
    check("b_unexpected", 32'(err_pulse), 32'h010);
    WVALID = 1; WREADY = 1; WLAST = 1; tick(); idle();
    check("w_no_aw", 32'(err_pulse), 32'h004);

    // AR stall timeout: one pulse only.
    do_reset();
    ARVALID = 1; ARREADY = 0; ARLEN = 8'd2;
    for (int i = 0; i < MAXWAIT - 1; i++) tick();
    check("timeout_not_yet", 32'(err_pulse), 0);
    tick();
    check("timeout_pulse", 32'(err_pulse), 32'h080);
    for (int i = 0; i < 5; i++) tick();
    check("timeout_once", 32'(err_pulse), 0);
    idle(); tick();

    // Reset mid-burst discards tracking.
    do_reset();
    AWVALID = 1; AWREADY = 1; AWLEN = 8'd7; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      WVALID = 1; WREADY = 1; WLAST = 0; tick();
    end
    do_reset();
    check("midburst_reset", {err_pulse, err_sticky, 3'(wr_outstanding), 3'(rd_outstanding)}, 0);
    AWVALID = 1; AWREADY = 1; AWLEN = 8'd0; tick(); idle();
    WVALID = 1; WREADY = 1; WLAST = 1; tick(); idle();
    BVALID = 1; BREADY = 1; tick(); idle();
    check("post_reset_clean", {err_sticky, 3'(wr_outstanding)}, 0);

`ifdef AMBA_AXI4_MON_STABILITY_EN
    do_reset();
    AWVALID = 1; AWREADY = 0; AWLEN = 8'd5; tick();
    AWLEN = 8'd6; tick(); idle();
    check("stability_awlen", 32'(err_pulse[8]), 1);
`endif

    // Random traffic.
    do_reset();
    rdy = 70;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy = 10;
          1: rdy = 70;
          default: rdy = 95;
        endcase
      end
      ARESETn = ($urandom_range(0, 299) != 0);
      AWVALID = ($urandom_range(0, 99) < 40);
      AWREADY = ($urandom_range(0, 99) < rdy);
      AWLEN   = 8'($urandom_range(0, 3));
      WVALID  = ($urandom_range(0, 99) < 60);
      WREADY  = ($urandom_range(0, 99) < rdy);
      if (aw_q.size() > 0) WLAST = (w_beat == aw_q[0]);
      else WLAST = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) WLAST = ~WLAST;
      BVALID  = ($urandom_range(0, 99) < 40);
      BREADY  = ($urandom_range(0, 99) < rdy);
      ARVALID = ($urandom_range(0, 99) < 40);
      ARREADY = ($urandom_range(0, 99) < rdy);
      ARLEN   = 8'($urandom_range(0, 3));
      RVALID  = ($urandom_range(0, 99) < 60);
      RREADY  = ($urandom_range(0, 99) < rdy);
      if (ar_q.size() > 0) RLAST = (r_beat == ar_q[0]);
      else RLAST = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) RLAST = ~RLAST;
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
